// File: rtl/decode_collate_buffer.sv
// Per-wavefront collation of multi-dword instructions ahead of decode.
// Each wavefront owns one partial-instruction slot; finished instructions queue in an in-order FIFO.
module decode_collate_buffer #(
  parameter int NUM_WF     = 40,
  parameter int WFID_W     = 6,
  parameter int MAX_DWORDS = 3,
  parameter int OUT_DEPTH  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WFID_W-1:0]       in_wfid,
  input  logic [31:0]             in_instr,
  input  logic [31:0]             in_pc,
  input  logic                    in_more,
  input  logic                    flush,
  input  logic [WFID_W-1:0]       flush_wfid,
  output logic                    req_valid,
  output logic [WFID_W-1:0]       req_wfid,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WFID_W-1:0]       out_wfid,
  output logic [31:0]             out_pc,
  output logic [32*MAX_DWORDS-1:0] out_instr,
  output logic [2:0]              out_ndwords,
  output logic                    err_overflow,
  output logic                    pending_any
);
  localparam int PTR_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int DW    = 32 * MAX_DWORDS;

  typedef struct packed {
    logic [WFID_W-1:0] wfid;
    logic [31:0]       pc;
    logic [DW-1:0]     instr;
    logic [2:0]        nd;
  } entry_t;

  logic [NUM_WF-1:0] busy_q, busy_d;
  logic [2:0]        cnt_q  [NUM_WF];
  logic [2:0]        cnt_d  [NUM_WF];
  logic [31:0]       pc_q   [NUM_WF];
  logic [31:0]       pc_d   [NUM_WF];
  logic [DW-1:0]     data_q [NUM_WF];
  logic [DW-1:0]     data_d [NUM_WF];

  entry_t            mem_q [OUT_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]    count_q;
  logic              req_valid_q, err_q, pending_q;
  logic [WFID_W-1:0] req_wfid_q;

  logic              sel_hit, sel_busy;
  logic [2:0]        sel_cnt, pos, new_cnt;
  logic [31:0]       sel_pc;
  logic [DW-1:0]     sel_data, push_data;
  logic              act, last, push, pop, ovf, req;
  entry_t            push_entry, head;

  // Slot lookup; an unmatched wfid (out of range) leaves sel_hit low so the word is dropped.
  always_comb begin
    sel_hit  = 1'b0;
    sel_busy = 1'b0;
    sel_cnt  = '0;
    sel_pc   = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_WF; i++) begin
      if (in_wfid == WFID_W'(i)) begin
        sel_hit  = 1'b1;
        sel_busy = busy_q[i];
        sel_cnt  = cnt_q[i];
        sel_pc   = pc_q[i];
        sel_data = data_q[i];
      end
    end
  end

  assign in_ready = (count_q != (PTR_W+1)'(OUT_DEPTH));
  assign pos      = sel_busy ? sel_cnt : 3'd0;
  assign new_cnt  = pos + 3'd1;
  assign act      = in_valid & in_ready & sel_hit & ~(flush & (flush_wfid == in_wfid));
  assign last     = ~in_more | (new_cnt == 3'(MAX_DWORDS));
  assign push     = act & last;
  assign ovf      = act & in_more & (new_cnt == 3'(MAX_DWORDS));
  assign req      = act & ~last;
  assign pop      = out_valid & out_ready;

  always_comb begin
    push_data = '0;
    for (int k = 0; k < MAX_DWORDS; k++) begin
      if (3'(k) < pos)       push_data[32*k +: 32] = sel_data[32*k +: 32];
      else if (3'(k) == pos) push_data[32*k +: 32] = in_instr;
    end
    push_entry.wfid  = in_wfid;
    push_entry.pc    = sel_busy ? sel_pc : in_pc;
    push_entry.instr = push_data;
    push_entry.nd    = new_cnt;
  end

  // Flush takes priority over a word for the same slot (act already excludes that case).
  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    pc_d   = pc_q;
    data_d = data_q;
    for (int i = 0; i < NUM_WF; i++) begin
      if (flush && (flush_wfid == WFID_W'(i))) begin
        busy_d[i] = 1'b0;
        cnt_d[i]  = '0;
        data_d[i] = '0;
      end else if (act && (in_wfid == WFID_W'(i))) begin
        if (push) begin
          busy_d[i] = 1'b0;
          cnt_d[i]  = '0;
          data_d[i] = '0;
        end else begin
          busy_d[i] = 1'b1;
          cnt_d[i]  = new_cnt;
          data_d[i] = push_data;
          if (!sel_busy) pc_d[i] = in_pc;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q <= '0;
      for (int i = 0; i < NUM_WF; i++) begin
        cnt_q[i]  <= '0;
        pc_q[i]   <= '0;
        data_q[i] <= '0;
      end
      pending_q   <= 1'b0;
      req_valid_q <= 1'b0;
      req_wfid_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      busy_q      <= busy_d;
      cnt_q       <= cnt_d;
      pc_q        <= pc_d;
      data_q      <= data_d;
      pending_q   <= |busy_d;
      req_valid_q <= req;
      err_q       <= ovf;
      if (req) req_wfid_q <= in_wfid;
    end
  end

  // Output FIFO; a push can only happen when not full because every accepted word needs in_ready.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int j = 0; j < OUT_DEPTH; j++) mem_q[j] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= push_entry;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
    end
  end

  assign head         = mem_q[rd_ptr_q];
  assign out_valid    = (count_q != '0);
  assign out_wfid     = out_valid ? head.wfid  : '0;
  assign out_pc       = out_valid ? head.pc    : '0;
  assign out_instr    = out_valid ? head.instr : '0;
  assign out_ndwords  = out_valid ? head.nd    : '0;
  assign req_valid    = req_valid_q;
  assign req_wfid     = req_wfid_q;
  assign err_overflow = err_q;
  assign pending_any  = pending_q;
endmodule

// File: tb/tb_decode_collate_buffer.sv
// Directed plus random stimulus for decode_collate_buffer, checked against a queue-based model.
module tb_decode_collate_buffer;
  localparam int NUM_WF = 40;
  localparam int WFID_W = 6;
  localparam int MAXD   = 3;
  localparam int DEPTH  = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0, in_ready, in_more = 1'b0, flush = 1'b0;
  logic [5:0]  in_wfid = '0, flush_wfid = '0, req_wfid, out_wfid;
  logic [31:0] in_instr = '0, in_pc = '0, out_pc;
  logic        req_valid, out_valid, out_ready = 1'b1, err_overflow, pending_any;
  logic [95:0] out_instr;
  logic [2:0]  out_ndwords;

  always #5 clk = ~clk;

  decode_collate_buffer #(.NUM_WF(NUM_WF), .WFID_W(WFID_W), .MAX_DWORDS(MAXD), .OUT_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_wfid(in_wfid),
    .in_instr(in_instr), .in_pc(in_pc), .in_more(in_more), .flush(flush), .flush_wfid(flush_wfid),
    .req_valid(req_valid), .req_wfid(req_wfid), .out_valid(out_valid), .out_ready(out_ready),
    .out_wfid(out_wfid), .out_pc(out_pc), .out_instr(out_instr), .out_ndwords(out_ndwords),
    .err_overflow(err_overflow), .pending_any(pending_any)
  );

  typedef struct {
    logic [5:0]  wfid;
    logic [31:0] pc;
    logic [95:0] instr;
    logic [2:0]  nd;
  } ent_t;

  ent_t         exp_q[$];
  logic         m_busy [NUM_WF];
  int           m_n    [NUM_WF];
  logic [31:0]  m_pc   [NUM_WF];
  logic [127:0] m_dat  [NUM_WF];
  logic         exp_req, exp_err, last_acc;
  logic [5:0]   exp_req_wf;
  int           checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_WF; i++) begin
      m_busy[i] = 1'b0; m_n[i] = 0; m_pc[i] = '0; m_dat[i] = '0;
    end
    exp_q.delete();
    exp_req = 1'b0; exp_err = 1'b0; exp_req_wf = '0;
  endtask

  function automatic logic any_busy();
    logic r = 1'b0;
    for (int i = 0; i < NUM_WF; i++) r |= m_busy[i];
    return r;
  endfunction

  task automatic check_outputs();
    chk("out_valid", out_valid, exp_q.size() > 0);
    if (exp_q.size() > 0) begin
      chk("out_wfid", out_wfid, exp_q[0].wfid);
      chk("out_pc", out_pc, exp_q[0].pc);
      chk("out_instr", out_instr, exp_q[0].instr);
      chk("out_ndwords", out_ndwords, exp_q[0].nd);
    end
    chk("req_valid", req_valid, exp_req);
    if (exp_req) chk("req_wfid", req_wfid, exp_req_wf);
    chk("err_overflow", err_overflow, exp_err);
    chk("pending_any", pending_any, any_busy());
  endtask

  // One clock: predict from the inputs currently driven, advance the model, then check after the edge.
  task automatic cycle();
    logic exp_ready, pop, act, have_push;
    int   w;
    ent_t e;
    exp_ready = exp_q.size() < DEPTH;
    chk("in_ready", in_ready, exp_ready);
    last_acc  = in_valid && exp_ready;
    pop       = (exp_q.size() > 0) && out_ready;
    exp_req   = 1'b0;
    exp_err   = 1'b0;
    have_push = 1'b0;
    act = last_acc && (int'(in_wfid) < NUM_WF) && !(flush && flush_wfid == in_wfid);
    if (act) begin
      w = int'(in_wfid);
      if (!m_busy[w]) begin
        m_pc[w] = in_pc; m_n[w] = 0; m_dat[w] = '0;
      end
      m_dat[w][32*m_n[w] +: 32] = in_instr;
      m_n[w]++;
      if (!in_more || m_n[w] == MAXD) begin
        e.wfid = in_wfid; e.pc = m_pc[w]; e.instr = m_dat[w][95:0]; e.nd = 3'(m_n[w]);
        have_push = 1'b1;
        exp_err   = in_more;
        m_busy[w] = 1'b0; m_n[w] = 0;
      end else begin
        m_busy[w]  = 1'b1;
        exp_req    = 1'b1;
        exp_req_wf = in_wfid;
      end
    end
    if (flush && int'(flush_wfid) < NUM_WF) begin
      m_busy[int'(flush_wfid)] = 1'b0;
      m_n[int'(flush_wfid)]    = 0;
    end
    if (pop) void'(exp_q.pop_front());
    if (have_push) exp_q.push_back(e);
    @(posedge clk);
    #1;
    check_outputs();
    $display("cyc v=%0b wf=%0d more=%0b acc=%0b fl=%0b/%0d out_v=%0b out_wf=%0d nd=%0d req=%0b",
             in_valid, in_wfid, in_more, last_acc, flush, flush_wfid, out_valid, out_wfid, out_ndwords, req_valid);
  endtask

  task automatic put(input int wf, input logic [31:0] instr, input logic [31:0] pc, input logic more);
    in_valid = 1'b1; in_wfid = 6'(wf); in_instr = instr; in_pc = pc; in_more = more;
    cycle();
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0; flush = 1'b0;
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    int done, budget;
    model_reset();
    #12;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_req_valid", req_valid, 1'b0);
    chk("rst_req_wfid", req_wfid, 6'd0);
    chk("rst_err", err_overflow, 1'b0);
    chk("rst_pending", pending_any, 1'b0);
    chk("rst_out_wfid", out_wfid, 6'd0);
    chk("rst_out_pc", out_pc, 32'd0);
    chk("rst_out_instr", out_instr, 96'd0);
    chk("rst_out_nd", out_ndwords, 3'd0);
    @(negedge clk);
    rst = 1'b1;

    // Single word
    put(3, 32'hBF810000, 32'h100, 1'b0);
    chk("single_nd", out_ndwords, 3'd1);
    chk("single_instr", out_instr, 96'hBF810000);
    chk("single_pc", out_pc, 32'h100);
    chk("single_noreq", req_valid, 1'b0);
    idle(1);

    // Interleave, held at the output so both entries queue up
    out_ready = 1'b0;
    put(1, 32'hD2000000, 32'h40, 1'b1);
    chk("il_req1", req_wfid, 6'd1);
    put(2, 32'h7E000280, 32'h80, 1'b1);
    chk("il_req2", req_wfid, 6'd2);
    put(2, 32'h3F800000, 32'h0, 1'b0);
    put(1, 32'h00020501, 32'h0, 1'b0);
    chk("il_head_wf2", out_wfid, 6'd2);
    chk("il_head_pc2", out_pc, 32'h80);
    out_ready = 1'b1;
    idle(1);
    chk("il_head_wf1", out_wfid, 6'd1);
    chk("il_wf1_dw1", out_instr[63:32], 32'h00020501);
    idle(1);

    // Three-dword instruction
    put(5, 32'h11111111, 32'h200, 1'b1);
    put(5, 32'h22222222, 32'h0, 1'b1);
    put(5, 32'h33333333, 32'h0, 1'b0);
    chk("three_nd", out_ndwords, 3'd3);
    idle(1);

    // Overflow on the third word; fourth starts a fresh slot
    put(7, 32'hA0000001, 32'h300, 1'b1);
    put(7, 32'hA0000002, 32'h0, 1'b1);
    put(7, 32'hA0000003, 32'h0, 1'b1);
    chk("ovf_pulse", err_overflow, 1'b1);
    chk("ovf_nd", out_ndwords, 3'd3);
    put(7, 32'hA0000004, 32'h310, 1'b1);
    chk("ovf_pending", pending_any, 1'b1);
    put(7, 32'hA0000005, 32'h0, 1'b0);
    idle(1);

    // Backpressure: six single words, consumer stalled for a while
    out_ready = 1'b0;
    done = 0;
    budget = 0;
    while (done < 6 && budget < 40) begin
      if (budget == 8) out_ready = 1'b1;
      put(20 + done, 32'hC0DE0000 + 32'(done), 32'h400 + 32'(4 * done), 1'b0);
      if (last_acc) done++;
      if (budget == 7) chk("bp_accepted", 32'(done), 32'd4);
      budget++;
    end
    chk("bp_all_accepted", 32'(done), 32'd6);
    idle(6);

    // Flush collision and flush of a different slot
    put(9, 32'h99990000, 32'h500, 1'b1);
    flush = 1'b1; flush_wfid = 6'd9;
    put(9, 32'h99990001, 32'h0, 1'b0);
    flush = 1'b0;
    chk("flush_pending", pending_any, 1'b0);
    chk("flush_noout", out_valid, 1'b0);
    put(10, 32'h10100000, 32'h600, 1'b1);
    flush = 1'b1; flush_wfid = 6'd10;
    put(11, 32'h11110000, 32'h700, 1'b0);
    flush = 1'b0;
    chk("flush_other_out", out_wfid, 6'd11);
    put(45, 32'hDEAD0000, 32'h800, 1'b1);
    idle(2);

    // Reset mid-backpressure with a partial slot outstanding
    out_ready = 1'b0;
    put(4, 32'h44440000, 32'h900, 1'b1);
    for (int i = 0; i < 3; i++) put(30 + i, 32'h30300000 + 32'(i), 32'hA00, 1'b0);
    #2 rst = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 1'b0);
    chk("arst_pending", pending_any, 1'b0);
    chk("arst_out_pc", out_pc, 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    out_ready = 1'b1;
    put(6, 32'h66660000, 32'hB00, 1'b0);
    idle(1);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      in_valid   = ($urandom_range(0, 3) != 0);
      in_wfid    = ($urandom_range(0, 15) == 0) ? 6'($urandom_range(40, 63)) : 6'($urandom_range(0, 7));
      in_instr   = $urandom;
      in_pc      = $urandom;
      in_more    = ($urandom_range(0, 2) != 0);
      flush      = ($urandom_range(0, 9) == 0);
      flush_wfid = 6'($urandom_range(0, 7));
      out_ready  = ($urandom_range(0, 3) != 0);
      cycle();
    end
    out_ready = 1'b1;
    idle(8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/decode_collate_buffer.md
# decode_collate_buffer

Parametrised multi-wavefront instruction collation buffer for the decode stage. It sits between the wavepool-to-decode pipeline flops and the decode core. It accepts 32-bit instruction words tagged with a wavefront id and keeps an independent partial-instruction slot per wavefront, so long instructions and trailing literals from different wavefronts can interleave. It requests each further dword from the wavepool and delivers complete instructions of 1..MAX_DWORDS dwords through a ready/valid output FIFO.

## Interface
- NUM_WF, 40, number of wavefront slots; legal wfid range 0..NUM_WF-1
- WFID_W, 6, wfid width
- MAX_DWORDS, 3, maximum instruction length in dwords (2..4)
- OUT_DEPTH, 4, output FIFO entries (power of two, >=2)
- clk  in  1  clock; all state on rising edge
- rst  in  1  reset; asynchronous, active-low
- in_valid  in  1  input word valid
- in_ready  out  1  input accepted when in_valid&in_ready
- in_wfid  in  WFID_W  wavefront of input word
- in_instr  in  32  instruction dword
- in_pc  in  32  PC of the word; captured only for the first dword
- in_more  in  1  decode says another dword follows (long encoding or literal)
- flush  in  1  discard the partial instruction of flush_wfid
- flush_wfid  in  WFID_W  wavefront to flush
- req_valid  out  1  one-cycle pulse requesting the next dword
- req_wfid  out  WFID_W  wavefront of the request
- out_valid  out  1  FIFO head valid
- out_ready  in  1  consumer accepts head
- out_wfid  out  WFID_W  head wavefront
- out_pc  out  32  head PC (PC of first dword)
- out_instr  out  32*MAX_DWORDS  dword0 in bits [31:0], dword k in [32k+31:32k]; unused dwords zero
- out_ndwords  out  3  dwords in head (1..MAX_DWORDS)
- err_overflow  out  1  one-cycle pulse: instruction truncated at MAX_DWORDS
- pending_any  out  1  some slot holds a partial instruction

## Operation
- Per slot state: busy, cnt (dwords held), pc, data[MAX_DWORDS].
- Accepted word, slot not busy: data[0]<=in_instr, pc<=in_pc, cnt<=1. If in_more, set busy and issue a request. Otherwise push {wfid,pc,data,1} to the FIFO.
- Accepted word, slot busy: data[cnt]<=in_instr; in_pc ignored.
  - !in_more: push with ndwords=cnt+1, clear the slot.
  - in_more and cnt+1<MAX_DWORDS: cnt<=cnt+1, issue a request.
  - in_more and cnt+1==MAX_DWORDS: push with ndwords=MAX_DWORDS, clear the slot, pulse err_overflow.
- Pushed entries zero their unused dword fields.
- flush: clears busy/cnt/data of flush_wfid. It has no effect on FIFO entries already pushed.
- flush and an accepted word for the same wfid in the same cycle: flush wins, the word is dropped, no push, no request. Different wfids proceed independently.
- Input wfid >= NUM_WF: word accepted and dropped, no request.
- in_ready = FIFO occupancy < OUT_DEPTH, computed from registered occupancy with no same-cycle pop-through. This holds for every word, including words that do not complete an instruction.
- Simultaneous push and pop: occupancy unchanged, order preserved; FIFO is strictly in order of completion.
- pending_any = OR of all busy bits, registered.

## Timing
- Reset (rst low, asynchronous) clears the following:
  - All slots idle; FIFO empty.
  - out_valid, req_valid, err_overflow and pending_any all 0.
  - out_wfid, out_pc, out_instr, out_ndwords and req_wfid all 0.
- Reset asserted mid-instruction discards all partial and queued instructions. in_ready is 1 at the first edge after release.
- Completion latency: the word is accepted at edge N; out_valid is 1 after edge N, with head data stable.
- Head contents and out_valid stay stable while out_valid & !out_ready.
- req_valid/req_wfid are registered and asserted for exactly the cycle after the accepting edge. At most one request per cycle, since at most one word is accepted per cycle.
- err_overflow pulses in the same cycle the truncated entry becomes visible in the FIFO.
- No combinational path from in_* to out_*, or from out_ready to in_ready.

## Test plan
- Single word: wfid 3, instr 0xBF810000, pc 0x100, in_more=0. Required: out_valid next cycle, out_ndwords=1, out_instr[31:0]=0xBF810000, out_pc=0x100, no req_valid.
- Interleave:
  - Stimulus: wfid 1 dword 0xD2000000 (more=1, pc 0x40); wfid 2 dword 0x7E000280 (more=1, pc 0x80); wfid 2 literal 0x3F800000 (more=0); wfid 1 dword 0x00020501 (more=0).
  - Required: req pulses for wfid 1 then 2; output order wfid 2 (ndwords 2, pc 0x80) then wfid 1 (ndwords 2, pc 0x40, instr[63:32]=0x00020501).
- Three-dword instruction, MAX_DWORDS=3: more=1,1,0 on wfid 5. Required: two requests, one output with ndwords=3.
- Overflow: four words with more=1 on wfid 7. Required: output ndwords=3 with err_overflow pulse on the third word; the fourth word starts a new slot, pending_any=1.
- Backpressure: out_ready=0, six single-word instructions. Required: in_ready drops after 4 accepted; head held stable. With out_ready=1, all six arrive in order.
- Flush collision: wfid 9 partial (more=1), then flush_wfid=9 in the same cycle as wfid 9's second word. Required: no output, pending_any=0. A rst pulse mid-backpressure empties the FIFO, and out_valid drops asynchronously.
